// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions.
//   pc_state_t  : pipeline controller FSM state (RUN / HALTED)
//   hz_cause_t  : winning hazard cause, exported for debug and tracing
//   pipe_ctl_t  : packed bundle of PC / latch enables and flushes
//   REG_ZERO    : architectural zero register index
//   decode_cause: maps a hazard cause onto the enable/flush bundle
package cpu_types_pkg;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } pc_state_t;

    typedef enum logic [2:0] {
        HZ_NONE    = 3'd0,
        HZ_DWAIT   = 3'd1,
        HZ_BRANCH  = 3'd2,
        HZ_LOADUSE = 3'd3,
        HZ_JUMP    = 3'd4,
        HZ_IMISS   = 3'd5
    } hz_cause_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
    } pipe_ctl_t;

    // Everything held, nothing flushed: used in reset and HALTED.
    localparam pipe_ctl_t CTL_HOLD = '0;

    function automatic pipe_ctl_t decode_cause(input hz_cause_t cause);
        pipe_ctl_t ctl;
        ctl = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1,
                memwb_en: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0};
        case (cause)
            HZ_DWAIT: begin
                ctl = CTL_HOLD;
            end
            HZ_BRANCH: begin
                ctl.ifid_flush = 1'b1;
                ctl.idex_flush = 1'b1;
            end
            HZ_LOADUSE: begin
                // Hold PC and IF/ID, inject one bubble into ID/EX.
                ctl.pc_en      = 1'b0;
                ctl.ifid_en    = 1'b0;
                ctl.idex_flush = 1'b1;
            end
            HZ_JUMP: begin
                // Squash the delay-slot fetch.
                ctl.ifid_flush = 1'b1;
            end
            HZ_IMISS: begin
                // Keep PC, push a bubble into IF/ID, drain downstream.
                ctl.pc_en      = 1'b0;
                ctl.ifid_flush = 1'b1;
            end
            default: begin
            end
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/pipeline_control_if.sv
// Bundle of every pipeline-control signal except clock and reset.
//   inputs to the controller : ihit, dhit, mem_req, ex_load, ex_rd, id_rs,
//                              id_rt, id_care_rt, branch_taken, id_jump,
//                              mem_halt
//   outputs of the controller: pc_en, ifid_en, idex_en, exmem_en, memwb_en,
//                              ifid_flush, idex_flush, halt_out, stall_cnt,
//                              flush_cnt
// Modports: pcu (the controller) and tb (the environment driving it).
interface pipeline_control_if #(
    parameter int CNT_W  = 16,
    parameter int NREG_W = 5
);
    logic              ihit;
    logic              dhit;
    logic              mem_req;
    logic              ex_load;
    logic [NREG_W-1:0] ex_rd;
    logic [NREG_W-1:0] id_rs;
    logic [NREG_W-1:0] id_rt;
    logic              id_care_rt;
    logic              branch_taken;
    logic              id_jump;
    logic              mem_halt;

    logic              pc_en;
    logic              ifid_en;
    logic              idex_en;
    logic              exmem_en;
    logic              memwb_en;
    logic              ifid_flush;
    logic              idex_flush;
    logic              halt_out;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport pcu (
        input  ihit, dhit, mem_req, ex_load, ex_rd, id_rs, id_rt, id_care_rt,
               branch_taken, id_jump, mem_halt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush,
               idex_flush, halt_out, stall_cnt, flush_cnt
    );

    modport tb (
        output ihit, dhit, mem_req, ex_load, ex_rd, id_rs, id_rt, id_care_rt,
               branch_taken, id_jump, mem_halt,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush,
               idex_flush, halt_out, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_detect.sv
// Combinational fixed-priority hazard encoder.
//   in : mem_req, dhit, branch_taken, ex_load, ex_rd, id_rs, id_rt,
//        id_care_rt, id_jump, ihit
//   out: cause (hz_cause_t) - highest-priority active hazard
// Priority: DWAIT > BRANCH > LOADUSE > JUMP > IMISS > NONE.
module hazard_detect
    import cpu_types_pkg::*;
#(
    parameter int NREG_W = 5
) (
    input  logic              mem_req,
    input  logic              dhit,
    input  logic              branch_taken,
    input  logic              ex_load,
    input  logic [NREG_W-1:0] ex_rd,
    input  logic [NREG_W-1:0] id_rs,
    input  logic [NREG_W-1:0] id_rt,
    input  logic              id_care_rt,
    input  logic              id_jump,
    input  logic              ihit,
    output hz_cause_t         cause
);

    logic dwait;
    logic load_use;

    // A completing access (dhit) releases the freeze on the same edge, so
    // evaluation falls through to the lower-priority rules.
    assign dwait = mem_req & ~dhit;

    // Register zero is hard-wired and can never carry a dependency.
    assign load_use = ex_load
                    & (ex_rd != NREG_W'(REG_ZERO))
                    & ((ex_rd == id_rs) | (id_care_rt & (ex_rd == id_rt)));

    always_comb begin
        cause = HZ_NONE;
        if (dwait) begin
            cause = HZ_DWAIT;
        end else if (branch_taken) begin
            cause = HZ_BRANCH;
        end else if (load_use) begin
            cause = HZ_LOADUSE;
        end else if (id_jump & ihit) begin
            cause = HZ_JUMP;
        end else if (~ihit) begin
            cause = HZ_IMISS;
        end
    end

endmodule

// File: rtl/pipeline_control_unit.sv
// Hazard and sequencing controller for the five-stage pipeline latches.
//   CLK  : system clock, rising edge
//   nRST : asynchronous active-low reset
//   bus  : pipeline_control_if.pcu - hazard inputs, PC/latch enables and
//          flushes, sticky halt_out, saturating stall_cnt / flush_cnt
// Holds the RUN/HALTED FSM and the counters; the hazard priority lives in
// hazard_detect. Enables and flushes are combinational in RUN.
module pipeline_control_unit
    import cpu_types_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int NREG_W = 5
) (
    input  logic           CLK,
    input  logic           nRST,
    pipeline_control_if.pcu bus
);

    pc_state_t        state_reg;
    hz_cause_t        cause;
    pipe_ctl_t        ctl;
    logic             running;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] flush_cnt_reg;
    logic [CNT_W-1:0] stall_cnt_next;
    logic [CNT_W-1:0] flush_cnt_next;
    logic [CNT_W:0]   stall_sum;
    logic [CNT_W:0]   flush_sum;
    logic [1:0]       flush_inc;

    hazard_detect #(
        .NREG_W (NREG_W)
    ) u_hazard_detect (
        .mem_req      (bus.mem_req),
        .dhit         (bus.dhit),
        .branch_taken (bus.branch_taken),
        .ex_load      (bus.ex_load),
        .ex_rd        (bus.ex_rd),
        .id_rs        (bus.id_rs),
        .id_rt        (bus.id_rt),
        .id_care_rt   (bus.id_care_rt),
        .id_jump      (bus.id_jump),
        .ihit         (bus.ihit),
        .cause        (cause)
    );

    // nRST gates the outputs directly so they drop the instant reset
    // asserts, not at the next clock edge.
    assign running = nRST & (state_reg == RUN);

    always_comb begin
        ctl = CTL_HOLD;
        if (running) begin
            ctl = decode_cause(cause);
        end
    end

    assign bus.pc_en      = ctl.pc_en;
    assign bus.ifid_en    = ctl.ifid_en;
    assign bus.idex_en    = ctl.idex_en;
    assign bus.exmem_en   = ctl.exmem_en;
    assign bus.memwb_en   = ctl.memwb_en;
    assign bus.ifid_flush = ctl.ifid_flush;
    assign bus.idex_flush = ctl.idex_flush;
    assign bus.halt_out   = (state_reg == HALTED);
    assign bus.stall_cnt  = stall_cnt_reg;
    assign bus.flush_cnt  = flush_cnt_reg;

    // Saturating counters: one extra carry bit detects overflow, in which
    // case the counter pins at all-ones instead of wrapping.
    assign flush_inc = {1'b0, ctl.ifid_flush} + {1'b0, ctl.idex_flush};
    assign stall_sum = {1'b0, stall_cnt_reg} + (CNT_W+1)'(running & ~ctl.pc_en);
    assign flush_sum = {1'b0, flush_cnt_reg} + (CNT_W+1)'(flush_inc);

    always_comb begin
        stall_cnt_next = stall_sum[CNT_W] ? {CNT_W{1'b1}} : stall_sum[CNT_W-1:0];
        flush_cnt_next = flush_sum[CNT_W] ? {CNT_W{1'b1}} : flush_sum[CNT_W-1:0];
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg     <= RUN;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else if (state_reg == RUN) begin
            // The halt edge still advances MEM/WB so the halt writes back.
            if (bus.mem_halt) begin
                state_reg <= HALTED;
            end
            stall_cnt_reg <= stall_cnt_next;
            flush_cnt_reg <= flush_cnt_next;
        end
    end

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed self-checking bench for pipeline_control_unit.
module tb_pipeline_control_unit;

    localparam int CNT_W  = 16;
    localparam int NREG_W = 5;

    // Expected {pc,ifid,idex,exmem,memwb,ifid_flush,idex_flush}
    localparam logic [6:0] C_RUN   = 7'b1111100;
    localparam logic [6:0] C_HOLD  = 7'b0000000;
    localparam logic [6:0] C_BR    = 7'b1111111;
    localparam logic [6:0] C_LU    = 7'b0011101;
    localparam logic [6:0] C_JMP   = 7'b1111110;
    localparam logic [6:0] C_IMISS = 7'b0111110;

    logic CLK;
    logic nRST;
    int   n_vec;
    int   n_err;

    pipeline_control_if #(.CNT_W(CNT_W), .NREG_W(NREG_W)) bus ();

    pipeline_control_unit #(.CNT_W(CNT_W), .NREG_W(NREG_W)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("  ok %s: %h", tag, got);
        end
    endtask

    function automatic logic [31:0] ctl_vec();
        return 32'({bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en,
                    bus.memwb_en, bus.ifid_flush, bus.idex_flush});
    endfunction

    task automatic idle();
        bus.ihit = 1'b1;  bus.dhit = 1'b0;  bus.mem_req = 1'b0;
        bus.ex_load = 1'b0;  bus.ex_rd = '0;  bus.id_rs = '0;  bus.id_rt = '0;
        bus.id_care_rt = 1'b0;  bus.branch_taken = 1'b0;  bus.id_jump = 1'b0;
        bus.mem_halt = 1'b0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_ctl(input string tag, input logic [6:0] exp);
        #1;
        chk(tag, ctl_vec(), 32'(exp));
    endtask

    task automatic chk_cnt(input string tag, input int stall, input int flush);
        chk({tag, ".stall"}, 32'(bus.stall_cnt), 32'(stall));
        chk({tag, ".flush"}, 32'(bus.flush_cnt), 32'(flush));
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        idle();
        step();
        nRST = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        nRST  = 1'b0;
        idle();

        // Reset state
        step();
        chk_ctl("rst.ctl", C_HOLD);
        chk("rst.halt", 32'(bus.halt_out), 32'd0);
        chk_cnt("rst", 0, 0);
        nRST = 1'b1;

        // Idle run: ten clean cycles
        for (int i = 0; i < 10; i++) begin
            chk_ctl($sformatf("idle%0d", i), C_RUN);
            step();
        end
        chk_cnt("idle", 0, 0);

        // Load-use on rs: one bubble, then clear once the load moves on
        do_reset();
        bus.ex_load = 1'b1;  bus.ex_rd = 5'd8;  bus.id_rs = 5'd8;
        chk_ctl("lu.rs", C_LU);
        step();
        bus.ex_load = 1'b0;
        chk_ctl("lu.after", C_RUN);
        step();
        chk_cnt("lu", 1, 1);
        // r0 never hazards
        bus.ex_load = 1'b1;  bus.ex_rd = 5'd0;  bus.id_rs = 5'd0;
        chk_ctl("lu.r0", C_RUN);
        step();
        // rt match ignored when rt not read, honoured when it is
        bus.ex_rd = 5'd8;  bus.id_rs = 5'd3;  bus.id_rt = 5'd8;  bus.id_care_rt = 1'b0;
        chk_ctl("lu.rt_nocare", C_RUN);
        step();
        bus.id_care_rt = 1'b1;
        chk_ctl("lu.rt_care", C_LU);
        step();
        idle();
        step();
        chk_cnt("lu2", 2, 2);

        // Data wait holds a taken branch, then dhit releases it
        do_reset();
        bus.mem_req = 1'b1;  bus.branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk_ctl($sformatf("dwait%0d", i), C_HOLD);
            step();
        end
        bus.dhit = 1'b1;
        chk_ctl("dwait.release", C_BR);
        step();
        idle();
        chk_ctl("dwait.after", C_RUN);
        chk_cnt("dwait", 3, 2);

        // Fetch miss with a jump in ID, then the jump flush
        do_reset();
        bus.ihit = 1'b0;  bus.id_jump = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk_ctl($sformatf("imiss%0d", i), C_IMISS);
            step();
        end
        bus.ihit = 1'b1;
        chk_ctl("jump", C_JMP);
        step();
        idle();
        chk_cnt("jump", 4, 5);

        // Counter saturation
        do_reset();
        bus.ihit = 1'b0;
        for (int i = 0; i < 65534; i++) @(posedge CLK);
        #1;
        chk_cnt("sat.fffe", 32'hFFFE, 32'hFFFE);
        step();
        chk_cnt("sat.ffff", 32'hFFFF, 32'hFFFF);
        for (int i = 0; i < 5; i++) @(posedge CLK);
        #1;
        chk_cnt("sat.hold", 32'hFFFF, 32'hFFFF);

        // Halt: write-back edge, sticky HALTED, async reset exit
        do_reset();
        bus.branch_taken = 1'b1;
        step();
        idle();
        bus.mem_halt = 1'b1;
        chk_ctl("halt.edge", C_RUN);
        chk("halt.pre", 32'(bus.halt_out), 32'd0);
        step();
        chk("halt.set", 32'(bus.halt_out), 32'd1);
        bus.mem_halt = 1'b0;  bus.branch_taken = 1'b1;  bus.ihit = 1'b0;
        chk_ctl("halted.ctl", C_HOLD);
        for (int i = 0; i < 3; i++) step();
        chk("halted.sticky", 32'(bus.halt_out), 32'd1);
        chk_cnt("halted", 0, 2);
        #2;
        nRST = 1'b0;
        #1;
        chk("arst.halt", 32'(bus.halt_out), 32'd0);
        chk("arst.ctl", ctl_vec(), 32'(C_HOLD));
        chk_cnt("arst", 0, 0);
        step();
        nRST = 1'b1;
        idle();
        chk_ctl("arst.run", C_RUN);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_control_unit.md
Name: pipeline_control_unit

Overview:
- Hazard and sequencing controller for the five-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generates the per-latch enable and flush signals, the PC enable and the sticky halt.
- Resolves memory waits, taken-branch redirects, load-use hazards, jumps and fetch misses under one fixed priority.
- Keeps saturating performance counters for stall cycles and squashed instructions.

Parameters:
- CNT_W, 16, width of each performance counter.
- NREG_W, 5, register-index width.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- ihit  in  1  instruction-cache data valid (level).
- dhit  in  1  data-cache access complete (pulse or level).
- mem_req  in  1  EX/MEM latch holds a load or store (dREN | dWEN).
- ex_load  in  1  ID/EX latch holds a load (MemToReg).
- ex_rd  in  NREG_W  destination register of the ID/EX instruction.
- id_rs  in  NREG_W  rs field of the IF/ID instruction.
- id_rt  in  NREG_W  rt field of the IF/ID instruction.
- id_care_rt  in  1  IF/ID instruction reads rt.
- branch_taken  in  1  branch resolved taken in EX.
- id_jump  in  1  jump (j/jal/jr) decoded in ID.
- mem_halt  in  1  halt instruction is in the MEM/WB latch.
- pc_en  out  1  PC register load enable.
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch advance enables.
- ifid_flush, idex_flush  out  1 each  load a bubble (all-zero control) on this edge.
- halt_out  out  1  sticky halt to the system.
- stall_cnt  out  CNT_W  cycles in which pc_en=0 while in RUN.
- flush_cnt  out  CNT_W  instructions squashed (one count per asserted flush per cycle).

Behaviour:
- Reset (nRST low, async):
  - state=RUN; counters=0; halt_out=0.
  - All enables and flushes are forced 0 for the whole reset period.
- FSM has two states, RUN and HALTED.
  - RUN→HALTED on the edge where mem_halt=1. That edge still has memwb_en=1, so the halt writes back.
  - HALTED is left only by reset.
  - In HALTED: all enables and flushes 0, halt_out=1 (registered, rising one cycle after mem_halt), counters frozen.
- In RUN, outputs are combinational from the inputs. The first matching rule applies:
  1. DWAIT (mem_req & !dhit): every enable is 0 and no flush. The whole pipe freezes and the EX branch is held.
  2. BRANCH (branch_taken): pc_en=1 (PC loads the target). All latch enables are 1. ifid_flush=1 and idex_flush=1. This applies regardless of ihit.
  3. LOADUSE: condition is ex_load & ex_rd≠0 & (ex_rd==id_rs | (id_care_rt & ex_rd==id_rt)).
     - pc_en=0 and ifid_en=0.
     - idex_en=1 with idex_flush=1.
     - exmem_en=1 and memwb_en=1.
     - Exactly one bubble per hazard: the next cycle the load is in MEM, so the condition clears.
  4. JUMP (id_jump & ihit): pc_en=1, all latch enables 1, ifid_flush=1. The delay-slot fetch is squashed.
  5. IMISS (!ihit): pc_en=0. ifid_en=1 with ifid_flush=1. Downstream latches advance.
  6. Default: all enables 1, no flush.
- If mem_req & dhit occur on the same cycle as a lower rule, evaluation continues from rule 2 (dhit releases the freeze on that same edge).
- Register 0 never creates a load-use hazard.
- Counters:
  - stall_cnt increments on every RUN cycle with pc_en=0.
  - flush_cnt adds ifid_flush+idex_flush each cycle (0..2).
  - Both saturate at 2^CNT_W−1 and never wrap.
- A flush asserted with its enable 0 has no effect. The unit never emits that combination.

Decomposition:
- cpu_types_pkg gains:
  - enum pc_state_t {RUN, HALTED}.
  - enum hz_cause_t {HZ_NONE, HZ_DWAIT, HZ_BRANCH, HZ_LOADUSE, HZ_JUMP, HZ_IMISS}, exported for debug and tracing.
  - localparam REG_ZERO=5'd0.
- New interface pipeline_control_if carries every port except CLK/nRST. Its modports are pcu (this block) and tb.
- One sub-module: hazard_detect, the combinational priority encoder producing hz_cause_t. The parent holds the FSM, the counters and output decode.

Test Plan:
- Reset, then ihit=1 with all other inputs 0: all enables 1, no flush, stall_cnt=0 after 10 cycles.
- ex_load=1, ex_rd=8, id_rs=8: exactly 1 cycle of pc_en=0, ifid_en=0, idex_flush=1. Repeating with ex_rd=0 gives no stall. Repeating with id_rt=8 and id_care_rt=0 gives no stall.
- mem_req=1 for 3 cycles, then dhit=1 with branch_taken=1: 3 frozen cycles (all enables 0), then a redirect with both flushes. stall_cnt=3, flush_cnt=2.
- ihit=0 for 4 cycles while id_jump=1: 4 IMISS bubbles (ifid_flush=1, pc_en=0). When ihit returns, one JUMP flush. flush_cnt=5.
- Preload stall_cnt near 0xFFFF by holding ihit=0 for 65540 cycles: the count sticks at 0xFFFF.
- mem_halt=1 pulse: memwb_en=1 on that edge, then HALTED with halt_out=1 and all enables 0 despite further stimulus. Pulse nRST low mid-HALTED: everything returns to reset values immediately, without waiting for a clock edge.
